// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared helpers for the parametrised register bank.
// Holds the default reset constant, the byte strobe-merge and the address range check.
// The optional shadow/commit stage is enabled by defining REG_BANK_SHADOW_EN.
package reg_bank_pkg;

  // Wide enough for any supported DATA_W; callers slice the low DATA_W bits.
  localparam logic [255:0] RST_VAL_DEFAULT = '0;

  // Strobe merge at byte granularity: the enabled byte takes the new value,
  // otherwise the old byte is kept.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_bank_word.sv
// reg_bank_word: one DATA_W register with byte-strobed write and an optional shadow stage.
// Latency: write visible on rd_q after 1 edge; q follows 1 edge after write (or after commit with shadow).
// Backpressure: none, accepts one write per cycle.
// Ports: clk, rst (async active-high), wr_en/wr_data/wr_strb (pre-decoded write),
//        commit (shadow copy, REG_BANK_SHADOW_EN only), q (active value), rd_q (read view).
module reg_bank_word
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = RST_VAL_DEFAULT[DATA_W-1:0]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                commit,
  output logic [DATA_W-1:0]   q,
  output logic [DATA_W-1:0]   rd_q
);

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      merged[i*8 +: 8] = merge_byte(base[i*8 +: 8], wr_data[i*8 +: 8], wr_strb[i]);
    end
  end

`ifdef REG_BANK_SHADOW_EN
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] active_q;

  assign base = shadow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      if (wr_en) begin
        shadow_q <= merged;
      end
      // A write landing in the commit cycle is copied through in merged form.
      if (commit) begin
        active_q <= wr_en ? merged : shadow_q;
      end
    end
  end

  assign q    = active_q;
  assign rd_q = shadow_q;
`else
  logic [DATA_W-1:0] active_q;
  logic              commit_unused;

  assign base          = active_q;
  assign commit_unused = commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= RST_VAL;
    end else if (wr_en) begin
      active_q <= merged;
    end
  end

  assign q    = active_q;
  assign rd_q = active_q;
`endif

endmodule

// File: rtl/reg_bank_param.sv
// reg_bank_param: NUM_REGS x DATA_W register bank with byte strobes, registered read and range errors.
// Latency: read response 1 cycle, fully pipelined; wr_err/rd_err 1 cycle after the request.
// Backpressure: none, one write and one read accepted every cycle.
// Ports: clk, rst (async active-high); wr_en/wr_addr/wr_data/wr_strb write port, wr_err pulse;
//        rd_en/rd_addr request, rd_valid/rd_data/rd_err response; commit; q_all active contents.
// Optional shadow/commit double-buffering: define REG_BANK_SHADOW_EN.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int                NUM_REGS = 4,
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] RST_VAL  = RST_VAL_DEFAULT[DATA_W-1:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_err,
  output logic                       wr_err,
  input  logic                       commit,
  output logic [NUM_REGS*DATA_W-1:0] q_all
);

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_q [NUM_REGS];
  logic [DATA_W-1:0] rd_word;

  assign wr_ok = addr_in_range(32'(wr_addr), NUM_REGS);
  assign rd_ok = addr_in_range(32'(rd_addr), NUM_REGS);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
    logic wr_sel;
    assign wr_sel = wr_en && (wr_addr == ADDR_W'(k));

    reg_bank_word #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_sel),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .commit  (commit),
      .q       (q_all[k*DATA_W +: DATA_W]),
      .rd_q    (rd_q[k])
    );
  end

  // Pre-edge register value; an out-of-range address selects nothing and reads 0.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        rd_word = rd_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_ok;
      wr_err   <= wr_en && !wr_ok;
      // rd_data holds between responses.
      if (rd_en) begin
        rd_data <= rd_ok ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// tb_reg_bank_param: directed scoreboard bench for reg_bank_param (NUM_REGS=4, DATA_W=32).
// Driver pushes one expected response per driven cycle; monitor pops after each edge.
// Follows REG_BANK_SHADOW_EN for q_all expectations.
module tb_reg_bank_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_strb;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_err;
  logic         wr_err;
  logic         commit;
  logic [127:0] q_all;

  typedef struct {
    logic        rv;
    logic        re;
    logic [31:0] rd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rd = '0;

  reg_bank_param #(
    .NUM_REGS (4),
    .DATA_W   (32),
    .ADDR_W   (6),
    .RST_VAL  (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .wr_err   (wr_err),
    .commit   (commit),
    .q_all    (q_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic re, input logic [5:0] ra,
                       input logic cm, input logic exp_re, input logic [31:0] exp_rd,
                       input logic exp_we);
    exp_t e;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_strb = ws;
    rd_en   = re;
    rd_addr = ra;
    commit  = cm;
    e.rv = re;
    e.re = exp_re;
    e.rd = exp_rd;
    e.we = exp_we;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input logic re, input logic [5:0] ra,
                     input logic cm, input logic exp_re, input logic [31:0] exp_rd,
                     input logic exp_we);
    @(negedge clk);
    drive(we, wa, wd, ws, re, ra, cm, exp_re, exp_rd, exp_we);
  endtask

  task automatic check_q(input string name, input logic [127:0] exp);
    @(negedge clk);
    chk(name, q_all, exp);
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compares what the DUT presents after each edge against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      last_rd = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_valid", 128'(rd_valid), 128'(e.rv));
      chk("wr_err", 128'(wr_err), 128'(e.we));
      if (e.rv) begin
        last_rd = e.rd;
        chk("rd_err", 128'(rd_err), 128'(e.re));
      end
      chk("rd_data", 128'(rd_data), 128'(last_rd));
    end else begin
      chk("idle_rd_valid", 128'(rd_valid), 128'(1'b0));
      chk("idle_wr_err", 128'(wr_err), 128'(1'b0));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0; commit = 1'b0;
    #3;
    chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("rst_rd_err", 128'(rd_err), 128'(1'b0));
    chk("rst_wr_err", 128'(wr_err), 128'(1'b0));
    chk("rst_rd_data", 128'(rd_data), 128'h0);
    chk("rst_q_all", q_all, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // Read every register after reset.
    for (int a = 0; a < 4; a++) begin
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'(a), 1'b0, 1'b0, 32'h0, 1'b0);
    end

    // Full write then partial strobe write to addr 2.
    cyc(1'b1, 6'd2, 32'hAABBCCDD, 4'hF, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 6'd2, 32'h11223344, 4'h5, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd2, 1'b0, 1'b0, 32'hAA22CC44, 1'b0);
`ifdef REG_BANK_SHADOW_EN
    check_q("q_after_strb", 128'h0);
`else
    check_q("q_after_strb", 128'h00000000_AA22CC44_00000000_00000000);
`endif

    // Read-before-write on the same address.
    cyc(1'b1, 6'd1, 32'h12345678, 4'hF, 1'b1, 6'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd1, 1'b0, 1'b0, 32'h12345678, 1'b0);

    // Out-of-range write and read in the same cycle.
    cyc(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b1, 6'd7, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef REG_BANK_SHADOW_EN
    check_q("q_after_oor", 128'h0);
`else
    check_q("q_after_oor", 128'h00000000_AA22CC44_12345678_00000000);
`endif

    // All-zero strobe is a silent no-op.
    cyc(1'b1, 6'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Shadow/commit behaviour (commit ignored when the shadow stage is absent).
    cyc(1'b1, 6'd0, 32'hCAFEF00D, 4'hF, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef REG_BANK_SHADOW_EN
    check_q("q_before_commit", 128'h0);
`else
    check_q("q_before_commit", 128'h00000000_AA22CC44_12345678_CAFEF00D);
`endif
    cyc(1'b1, 6'd3, 32'h00000001, 4'hF, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_q("q_after_commit", 128'h00000001_AA22CC44_12345678_CAFEF00D);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_q("q_idle_commit", 128'h00000001_AA22CC44_12345678_CAFEF00D);

    // Reset in the middle of a read stream.
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd1, 1'b0, 1'b0, 32'h12345678, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd2, 1'b0, 1'b0, 32'hAA22CC44, 1'b0);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 6'd3;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("midrst_rd_data", 128'(rd_data), 128'h0);
    chk("midrst_q_all", q_all, 128'h0);
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b0;

    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
